ascon_hash_ctrl: RTL and testbench

//  Initiator-side sequencer that drives ascon_core's word/permutation interface to compute Ascon-Hash256 (SP 800-232).

---
 rtl/ascon_hash_ctrl.sv | 122 ++++++++++++
 tb/tb_ascon_hash_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_hash_ctrl.sv
// ascon_hash_ctrl: sequences ascon_core through Ascon-Hash256 absorb/squeeze,
// taking a 64-bit message stream and emitting a 4-word digest stream.
`timescale 1ns/1ps
module ascon_hash_ctrl #(
    parameter logic [63:0] HASH_IV   = 64'h0000_0801_00CC_0002,
    parameter int          OUT_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    input  logic [63:0] msg_data,
    input  logic [3:0]  msg_bytes,
    input  logic        msg_last,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [63:0] dig_data,
    output logic        dig_valid,
    output logic        dig_last,
    input  logic        dig_ready,
    output logic        core_start,
    output logic        core_rnd,
    output logic [2:0]  core_sel,
    output logic [63:0] core_wdata,
    output logic        core_wr,
    output logic        core_xor,
    input  logic [63:0] core_rdata,
    input  logic        core_ready
);
    typedef enum logic [2:0] {IDLE, INIT, PERM, PWAIT, ABSORB, PAD, READ, SQUEEZE} state_t;
    state_t      state, state_d, ret, ret_d;
    logic [2:0]  cnt, cnt_d;
    logic        first;
    logic [3:0]  nb;
    logic [5:0]  sh;
    logic [63:0] padded;
    assign busy   = state != IDLE;
    assign nb     = msg_bytes > 4'd8 ? 4'd8 : msg_bytes;
    assign sh     = {nb[2:0], 3'b000};
    // keep only the valid low bytes, then append the 0x01 padding byte
    assign padded = (msg_data & ~(64'hFFFF_FFFF_FFFF_FFFF << sh)) | (64'd1 << sh);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ret      <= IDLE;
            cnt      <= '0;
            first    <= 1'b0;
            dig_data <= '0;
            core_rnd <= 1'b0;
        end else begin
            state    <= state_d;
            ret      <= ret_d;
            cnt      <= cnt_d;
            first    <= state == PERM;
            core_rnd <= 1'b1;
            if (state == READ) dig_data <= core_rdata;
        end
    end
    always_comb begin
        state_d    = state;
        ret_d      = ret;
        cnt_d      = cnt;
        msg_ready  = 1'b0;
        dig_valid  = 1'b0;
        dig_last   = 1'b0;
        core_start = 1'b0;
        core_sel   = 3'd0;
        core_wdata = 64'd0;
        core_wr    = 1'b0;
        core_xor   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    cnt_d   = 3'd0;
                end
            end
            INIT: begin
                core_wr    = 1'b1;
                core_sel   = cnt;
                core_wdata = cnt == 3'd0 ? HASH_IV : 64'd0;
                cnt_d      = cnt == 3'd4 ? 3'd0 : cnt + 3'd1;
                if (cnt == 3'd4) begin
                    state_d = PERM;
                    ret_d   = ABSORB;
                end
            end
            PERM: begin
                core_start = 1'b1;
                state_d    = PWAIT;
            end
            // the core may still show ready the cycle right after the start pulse
            PWAIT: state_d = (!first && core_ready) ? ret : PWAIT;
            ABSORB: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    core_xor   = 1'b1;
                    core_wdata = (msg_last && !nb[3]) ? padded : msg_data;
                    state_d    = PERM;
                    ret_d      = !msg_last ? ABSORB : nb[3] ? PAD : READ;
                end
            end
            PAD: begin
                core_xor   = 1'b1;
                core_wdata = 64'd1;
                state_d    = PERM;
                ret_d      = READ;
            end
            READ: state_d = SQUEEZE;
            SQUEEZE: begin
                dig_valid = 1'b1;
                dig_last  = cnt == 3'(OUT_WORDS - 1);
                if (dig_ready) begin
                    state_d = dig_last ? IDLE : PERM;
                    ret_d   = READ;
                    cnt_d   = dig_last ? cnt : cnt + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// tb_ascon_hash_ctrl: drives ascon_hash_ctrl against a behavioural ascon_core
// and checks digests against a byte-level Ascon-Hash256 reference.
`timescale 1ns/1ps
module tb_ascon_hash_ctrl;
    localparam logic [63:0] IV = 64'h0000_0801_00CC_0002;
    logic        clk = 0, rst_n = 0, start = 0;
    logic        busy, msg_ready, dig_valid, dig_last, core_start, core_rnd, core_wr, core_xor;
    logic [63:0] msg_data = 0, dig_data, core_wdata, core_rdata;
    logic [3:0]  msg_bytes = 0;
    logic        msg_last = 0, msg_valid = 0, dig_ready = 0, core_ready = 1;
    logic [2:0]  core_sel;
    int n_vec = 0, n_err = 0;
    int core_lat = 3, busy_cnt = 0, n_perm = 0, n_xor = 0, n_hs = 0;
    logic        both_seen = 0;
    logic [63:0] last_xor = 0;
    logic [4:0][63:0] st = '0;
    logic [3:0][63:0] kat_empty = {64'hB2924D30AA3BD59B, 64'h838F9B24AA70FAA1,
                                   64'h649BA8DE8F9FF2CA, 64'h986B2F0F85E53B0B};

    always #5 clk = ~clk;

    ascon_hash_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .msg_data(msg_data), .msg_bytes(msg_bytes), .msg_last(msg_last),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_last(dig_last), .dig_ready(dig_ready),
        .core_start(core_start), .core_rnd(core_rnd), .core_sel(core_sel),
        .core_wdata(core_wdata), .core_wr(core_wr), .core_xor(core_xor),
        .core_rdata(core_rdata), .core_ready(core_ready)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] p12(input logic [4:0][63:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x4, x3, x2, x1, x0} = s;
        for (int r = 0; r < 12; r++) begin
            x2 ^= 64'(240 - 15 * r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1) ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7) ^ ror(x4, 41);
        end
        return {x4, x3, x2, x1, x0};
    endfunction

    // Ascon-Hash256 over a byte string: pad with 0x01 then zeros, absorb 8-byte LE blocks
    function automatic logic [3:0][63:0] ref_hash(input byte unsigned m[$]);
        logic [4:0][63:0] s;
        logic [3:0][63:0] d;
        logic [63:0] w;
        byte unsigned q[$];
        q = m;
        q.push_back(8'h01);
        while (q.size() % 8 != 0) q.push_back(8'h00);
        s = '0;
        s[0] = IV;
        s = p12(s);
        for (int k = 0; k < q.size() / 8; k++) begin
            w = 0;
            for (int b = 0; b < 8; b++) w[8*b +: 8] = q[8*k + b];
            s[0] ^= w;
            s = p12(s);
        end
        for (int i = 0; i < 4; i++) begin
            d[i] = s[0];
            if (i < 3) s = p12(s);
        end
        return d;
    endfunction

    // behavioural ascon_core: word writes/xors, p12 completing core_lat cycles after start
    assign core_rdata = core_sel < 3'd5 ? st[core_sel] : 64'd0;
    always @(posedge clk) begin
        if (core_wr) st[core_sel] <= core_wdata;
        else if (core_xor) begin
            st[core_sel] <= st[core_sel] ^ core_wdata;
            n_xor <= n_xor + 1;
            last_xor <= core_wdata;
        end
        if (core_wr && core_xor) both_seen <= 1;
        if (dig_valid && dig_ready) n_hs <= n_hs + 1;
        if (core_start) begin
            busy_cnt <= core_lat;
            core_ready <= 0;
            n_perm <= n_perm + 1;
        end else if (busy_cnt == 1) begin
            st <= p12(st);
            core_ready <= 1;
            busy_cnt <= 0;
        end else if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {63'd0, |{busy, msg_ready, dig_data, dig_valid, dig_last, core_start,
                           core_rnd, core_sel, core_wdata, core_wr, core_xor}}, 0);
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
        int t = 0;
        msg_data = d; msg_bytes = nb; msg_last = last; msg_valid = 1;
        @(negedge clk);
        while (!msg_ready && t < 500) begin @(negedge clk); t++; end
        chk("msg_accept", msg_ready, 1);
        @(posedge clk); #1;
        msg_valid = 0;
    endtask

    task automatic run_hash(input byte unsigned m[$], input logic [3:0][63:0] exp,
                            input int hold, input bit poke);
        int len, nw, nblk, pb, xb, hb, t, pp;
        logic [63:0] w, d0;
        logic [3:0] nb;
        logic stable;
        len = m.size();
        nw = len == 0 ? 1 : (len + 7) / 8;
        nblk = len / 8 + 1;
        pb = n_perm; xb = n_xor; hb = n_hs;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < nw; i++) begin
            nb = i == nw - 1 ? 4'(len - 8 * i) : 4'd8;
            w = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) if (b < nb) w[8*b +: 8] = m[8*i + b];
            if (i == nw - 1 && nb == 4'd8) nb = 4'($urandom_range(8, 15));
            send_word(w, nb, i == nw - 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        for (int k = 0; k < 4; k++) begin
            t = 0;
            @(negedge clk);
            while (!dig_valid && t < 500) begin @(negedge clk); t++; end
            chk("dig_valid_seen", dig_valid, 1);
            if (k == 0) begin
                chk("perm_count", n_perm - pb, nblk + 1);
                chk("xor_count", n_xor - xb, nblk);
                chk("pad_word", last_xor >> (8 * (len % 8)), 1);
                chk("core_rnd", core_rnd, 1);
            end
            if (hold > 0) begin
                d0 = dig_data; pp = n_perm; stable = 1;
                if (poke) start = 1;
                repeat (hold) begin
                    @(negedge clk);
                    if (dig_data !== d0 || !dig_valid) stable = 0;
                end
                start = 0;
                chk("hold_stable", stable, 1);
                chk("hold_no_perm", n_perm - pp, 0);
            end
            chk("dig_word", dig_data, exp[k]);
            chk("dig_last", dig_last, k == 3);
            dig_ready = 1;
            @(posedge clk); #1;
            dig_ready = 0;
        end
        @(negedge clk);
        chk("busy_done", busy, 0);
        chk("handshakes", n_hs - hb, 4);
        if (poke) begin
            repeat (3) @(negedge clk);
            chk("start_ignored", busy, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        byte unsigned m[$];
        repeat (2) @(negedge clk);
        chk_quiet("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) begin @(posedge clk); #1; end
        // empty message against the published digest
        m = {};
        run_hash(m, kat_empty, 0, 0);
        // exactly 8 bytes: separate padding block
        m = {};
        for (int i = 0; i < 8; i++) m.push_back(8'(i));
        core_lat = 2;
        run_hash(m, ref_hash(m), 0, 0);
        // three words, last holds 3 bytes
        m = {};
        repeat (19) m.push_back(8'($urandom));
        core_lat = 4;
        run_hash(m, ref_hash(m), 0, 0);
        // digest sink stalls 10 cycles on each word
        m = {};
        repeat ($urandom_range(0, 30)) m.push_back(8'($urandom));
        run_hash(m, ref_hash(m), 10, 0);
        // reset while waiting on an absorb permutation
        m = {};
        repeat (16) m.push_back(8'($urandom));
        start = 1;
        @(posedge clk); #1;
        start = 0;
        send_word({$urandom, $urandom}, 4'd8, 0);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk_quiet("mid_reset_outputs");
        repeat (3) @(negedge clk);
        chk_quiet("held_reset_outputs");
        @(posedge clk); #1;
        rst_n = 1;
        repeat (10) begin @(posedge clk); #1; end
        m = {};
        run_hash(m, kat_empty, 0, 0);
        // start pulsed while busy
        m = {};
        repeat ($urandom_range(1, 24)) m.push_back(8'($urandom));
        core_lat = 1;
        run_hash(m, ref_hash(m), 3, 1);
        // random messages, core latencies and stalls
        for (int n = 0; n < 8; n++) begin
            m = {};
            repeat ($urandom_range(0, 40)) m.push_back(8'($urandom));
            core_lat = $urandom_range(1, 5);
            run_hash(m, ref_hash(m), $urandom_range(0, 1) * $urandom_range(1, 4), 1'($urandom));
        end
        chk("wr_xor_exclusive", both_seen, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
